cbus_rr_arbiter: RTL and testbench
==================================

Name: cbus_rr_arbiter

Overview:
- Shares the single uncached/cache-refill bus (cbus) between several burst masters: I-cache refill, D-cache port 1, D-cache port 0, and an uncached path.
- Sits between the cache manager and the top-level `oreq`/`oresp`, in place of the plain mux.
- Grants one master at a time and holds the grant until that master's burst completes.
- Round-robin by default so that neither the I-side nor the D-side starves.

Parameters:
- NUM_REQ, 4, number of requesting masters; index 0 = lowest fixed priority.
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, highest index wins.
- SEL_W, $clog2(NUM_REQ), width of the grant index (derived; do not override).

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- ireqs  input  cbus_req_t[NUM_REQ]  per-master requests (valid, is_write, size, addr, strobe, data, len).
- iresps  output  cbus_resp_t[NUM_REQ]  per-master responses (ready, last, data).
- oreq  output  cbus_req_t  request to the memory-side bus.
- oresp  input  cbus_resp_t  response from the memory-side bus.
- busy  output  1  a grant is active.
- grant_idx  output  SEL_W  index of the granted master; valid only when busy=1.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `resetn` is asynchronous and active-low.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_idx=0, busy=0.
  - oreq all zeros; every iresps[i] all zeros.
- State IDLE:
  - oreq=0; all iresps=0.
  - If any ireqs[i].valid: choose a winner and register it in grant_idx. State goes to BUSY on the next edge.
  - Winner in round-robin mode: first valid index scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  - Winner in fixed mode: highest valid index.
  - Arbitration latency: 1 cycle from valid to oreq.valid. The decision cycle grants nothing.
- State BUSY:
  - oreq = ireqs[grant_idx], combinationally.
  - iresps[grant_idx] = oresp; every other iresps[j] = 0.
  - Requests from other masters are ignored and never see ready or last.
- BUSY -> IDLE on oresp.ready && oresp.last, sampled on the clock edge.
  - rr_ptr <= grant_idx+1, wrapping at NUM_REQ to 0.
  - grant_idx keeps its value; busy drops the next cycle.
- Back-to-back grants: a finished master always passes through one IDLE cycle before any new grant. Minimum gap between bursts is 1 cycle.
- Protocol rule for masters: valid and all request fields must stay stable from grant until last.
- Abort: if ireqs[grant_idx].valid drops while BUSY without a last, it is treated as an abort.
  - Return to IDLE next cycle and advance rr_ptr as on completion.
  - Memory-side behaviour after an abort is undefined. Simulation builds fire an assertion.
- Reset mid-burst: asynchronous return to reset values. No response is ever forwarded after resetn deasserts low.
- No combinational path from oresp to oreq. The path from ireqs to oreq is combinational through the mux only.
- rr_ptr arithmetic: SEL_W bits, explicit wrap; correct for non-power-of-two NUM_REQ.

Decomposition:
- cbus_req_t and cbus_resp_t stay in the existing shared bus package.
- Add arb_state_t (IDLE, BUSY) to cache_pkg.
- One natural sub-module: rr_pick. It is combinational: valid mask + start pointer -> winner index + any_valid.
- rr_pick is reused for fixed mode with a pointer tied to 0 and a reversed mask.

Test Plan:
- Single master: reset, then ireqs[2] reads len=4 at addr 0x1fc0_0000. oreq.valid rises one cycle after the request. iresps[2] sees 4 ready beats, last on beat 4. busy=0 the following cycle; rr_ptr=3.
- All four masters valid at once, each len=1, rr_ptr=0: grant order 0,1,2,3. Each burst is separated by one IDLE cycle. No master receives ready while another is granted.
- Master 3 continuously re-requests while master 1 requests once, starting with rr_ptr=3: order is 3, 1, 3. Master 1 waits at most one burst.
- FIXED_PRIO=1 with masters 0 and 3 both valid: master 3 wins each time. Master 0 is granted only once master 3's valid is low in the IDLE cycle.
- Write with strobe=4'hf, len=8, data=0xdead_beef: oreq mirrors every field unchanged for all 8 beats. Other iresps stay 0 throughout.
- resetn pulsed low during beat 3 of 8: outputs zero immediately (async). Next request is granted with rr_ptr=0. Abort case: dropping valid mid-burst returns the arbiter to IDLE in one cycle.

Source files
------------

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus types and arbiter state encoding.
//   cbus_req_t  : master -> memory request (valid, is_write, size, addr, strobe, data, len)
//   cbus_resp_t : memory -> master response (ready, last, data)
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
package cbus_rr_arbiter_pkg;

  localparam int CBUS_ADDR_W = 32;
  localparam int CBUS_DATA_W = 32;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;
  localparam int CBUS_LEN_W  = 8;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [2:0]             size;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
    logic [CBUS_LEN_W-1:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Combinational rotating picker.
//   mask      : one bit per requester, 1 = requesting
//   start     : index scanned first; the scan wraps modulo N
//   winner    : first set index found from start upward (0 when nothing is set)
//   any_valid : at least one mask bit is set
module cbus_rr_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] winner,
  output logic             any_valid
);

  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_s;
    winner    = '0;
    any_valid = |mask;
    idx       = 0;
    idx_s     = '0;
    // Scan from the far end back towards start so the closest hit is
    // written last and therefore wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      idx_s = SEL_W'(idx);
      if (mask[idx_s]) winner = idx_s;
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Burst arbiter sharing the single cbus between NUM_REQ masters.
//   clk, resetn : clock, asynchronous active-low reset
//   ireqs       : per-master requests
//   iresps      : per-master responses (only the granted master sees oresp)
//   oreq        : request forwarded to the memory-side bus
//   oresp       : response from the memory-side bus
//   busy        : a grant is active
//   grant_idx   : granted master, meaningful only while busy
//   dbg_state   : FSM state
//   dbg_rr_ptr  : round-robin start pointer
//
// Handshake: a master raises valid and holds valid plus every request field
// stable until it sees ready && last on its response. Each beat completes on
// a clock edge where oresp.ready is high; the beat with last high ends the
// burst. Dropping valid early aborts the burst.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FIXED_PRIO   = 0,
  parameter int SEL_W        = $clog2(NUM_REQ),
  parameter int ABORT_ASSERT = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        ireqs  [NUM_REQ],
  output cbus_resp_t       iresps [NUM_REQ],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [SEL_W-1:0] grant_idx,
  output arb_state_t       dbg_state,
  output logic [SEL_W-1:0] dbg_rr_ptr
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);
  localparam logic [SEL_W-1:0] ONE      = SEL_W'(1);

  arb_state_t         state_q, state_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] pick_mask;
  logic [SEL_W-1:0]   pick_start;
  logic [SEL_W-1:0]   pick_win;
  logic [SEL_W-1:0]   winner;
  logic               pick_any;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) req_valid[i] = ireqs[i].valid;
  end

  // Fixed priority reuses the rotating picker: reversing the mask and
  // starting at 0 makes the highest valid index come out first.
  if (FIXED_PRIO != 0) begin : g_fixed
    always_comb begin
      pick_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) pick_mask[i] = req_valid[NUM_REQ-1-i];
    end
    assign pick_start = '0;
    assign winner     = LAST_IDX - pick_win;
  end else begin : g_rr
    assign pick_mask  = req_valid;
    assign pick_start = rr_ptr_q;
    assign winner     = pick_win;
  end

  cbus_rr_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .mask      (pick_mask),
    .start     (pick_start),
    .winner    (pick_win),
    .any_valid (pick_any)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // oreq depends only on state and ireqs, so oresp never reaches oreq.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    oreq     = '0;
    for (int j = 0; j < NUM_REQ; j++) iresps[j] = '0;
    case (state_q)
      IDLE: begin
        // Decision cycle: register the winner, forward nothing yet.
        if (pick_any) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        oreq            = ireqs[grant_q];
        iresps[grant_q] = oresp;
        // Completion and abort both release the bus and rotate the pointer.
        if ((oresp.ready && oresp.last) || !ireqs[grant_q].valid) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == BUSY);
  assign grant_idx  = grant_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

  // A granted master dropping valid mid-burst leaves the memory side in an
  // undefined state; flag it in simulation.
  abort_seen: assert property (@(posedge clk) disable iff (!resetn)
    !((ABORT_ASSERT != 0) && state_q == BUSY && !ireqs[grant_q].valid));

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
module tb_cbus_rr_arbiter;
  import cbus_rr_arbiter_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  cbus_req_t        ireqs  [NUM_REQ];
  cbus_resp_t       iresps [NUM_REQ];
  cbus_req_t        oreq;
  cbus_resp_t       oresp;
  logic             busy;
  logic [SEL_W-1:0] grant_idx, dbg_rr_ptr;
  arb_state_t       dbg_state;

  cbus_req_t        f_ireqs  [NUM_REQ];
  cbus_resp_t       f_iresps [NUM_REQ];
  cbus_req_t        f_oreq;
  cbus_resp_t       f_oresp;
  logic             f_busy;
  logic [SEL_W-1:0] f_grant_idx, f_dbg_rr_ptr;
  arb_state_t       f_dbg_state;

  cbus_rr_arbiter #(.NUM_REQ(NUM_REQ), .FIXED_PRIO(0), .ABORT_ASSERT(0)) dut (
    .clk(clk), .resetn(resetn), .ireqs(ireqs), .iresps(iresps), .oreq(oreq),
    .oresp(oresp), .busy(busy), .grant_idx(grant_idx), .dbg_state(dbg_state),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  cbus_rr_arbiter #(.NUM_REQ(NUM_REQ), .FIXED_PRIO(1), .ABORT_ASSERT(1)) dut_fixed (
    .clk(clk), .resetn(resetn), .ireqs(f_ireqs), .iresps(f_iresps), .oreq(f_oreq),
    .oresp(f_oresp), .busy(f_busy), .grant_idx(f_grant_idx), .dbg_state(f_dbg_state),
    .dbg_rr_ptr(f_dbg_rr_ptr)
  );

  // ---------------- reference model + scoreboard ----------------
  int               n_cmp, n_err;
  bit               m_busy;
  int               m_gnt, m_ptr, mem_beat;
  int               reqs_left [NUM_REQ];
  int               beats_seen[NUM_REQ];
  int               last_at   [NUM_REQ];
  bit               rand_ready;
  logic [SEL_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] valid_mask();
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) v[i] = ireqs[i].valid;
    return v;
  endfunction

  // Round-robin rule: first requester met scanning ptr, ptr+1, ... mod NUM_REQ.
  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_req(input int i, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input int len);
    ireqs[i].valid    = 1'b1;
    ireqs[i].is_write = wr;
    ireqs[i].size     = 3'd2;
    ireqs[i].addr     = addr;
    ireqs[i].strobe   = strb;
    ireqs[i].data     = data;
    ireqs[i].len      = 8'(len);
  endtask

  task automatic load_rand(input int i);
    load_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom,
             4'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
  endtask

  task automatic master_done(input int i);
    reqs_left[i]--;
    if (reqs_left[i] <= 0) ireqs[i].valid = 1'b0;
    else load_rand(i);
  endtask

  task automatic drive_oresp();
    oresp.data = $urandom;
    if (m_busy) begin
      oresp.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      oresp.last  = oresp.ready && (mem_beat == int'(ireqs[m_gnt].len) - 1);
    end else begin
      // Garbage on the memory side while idle must not leak to any master.
      oresp.ready = 1'($urandom_range(0, 1));
      oresp.last  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_outputs();
    cbus_resp_t e;
    chk("busy", 128'(busy), 128'(m_busy));
    chk("state", 128'(dbg_state), 128'(m_busy ? BUSY : IDLE));
    chk("rr_ptr", 128'(dbg_rr_ptr), 128'(m_ptr));
    if (m_busy) begin
      chk("grant_idx", 128'(grant_idx), 128'(m_gnt));
      chk("oreq_mirror", 128'(oreq), 128'(ireqs[m_gnt]));
    end else begin
      chk("oreq_idle", 128'(oreq), 128'(0));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      e = (m_busy && i == m_gnt) ? oresp : '0;
      chk($sformatf("iresps%0d", i), 128'(iresps[i]), 128'(e));
      if (iresps[i].ready === 1'b1) begin
        beats_seen[i]++;
        if (iresps[i].last === 1'b1) last_at[i] = beats_seen[i];
      end
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model across the edge.
  task automatic tick();
    bit fin, done, start, beat;
    int g;
    #1;
    check_outputs();
    fin   = m_busy && oresp.ready && oresp.last;
    done  = fin || (m_busy && !ireqs[m_gnt].valid);
    beat  = m_busy && oresp.ready;
    start = !m_busy && (valid_mask() != '0);
    g     = model_pick(valid_mask(), m_ptr);
    @(posedge clk);
    #1;
    if (done) begin
      if (fin) master_done(m_gnt);
      m_ptr  = (m_gnt + 1) % NUM_REQ;
      m_busy = 1'b0;
    end else if (start) begin
      m_busy   = 1'b1;
      m_gnt    = g;
      mem_beat = 0;
      if (exp_q.size() != 0) chk("grant_order", 128'(grant_idx), 128'(exp_q.pop_front()));
    end else if (beat) begin
      mem_beat++;
    end
    drive_oresp();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while ((valid_mask() != '0 || m_busy) && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_timeout", 128'(valid_mask() != '0 || m_busy), 128'(0));
    tick();
  endtask

  task automatic clear_beats();
    for (int i = 0; i < NUM_REQ; i++) begin
      beats_seen[i] = 0;
      last_at[i]    = 0;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int fb[6];
    int fg[6];
    fb = '{0, 1, 0, 1, 0, 1};
    fg = '{0, 3, 0, 3, 0, 0};
    n_cmp = 0; n_err = 0;
    m_busy = 1'b0; m_gnt = 0; m_ptr = 0; mem_beat = 0; rand_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ireqs[i] = '0; f_ireqs[i] = '0; reqs_left[i] = 0;
    end
    clear_beats();
    f_oresp = '0;
    oresp   = '0;
    resetn  = 1'b0;

    // Reset values, with the memory side driving a live-looking response.
    #2;
    oresp.ready = 1'b1; oresp.last = 1'b1; oresp.data = 32'hffff_ffff;
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant_idx), 128'(0));
    chk("rst_rr_ptr", 128'(dbg_rr_ptr), 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(IDLE));
    chk("rst_oreq", 128'(oreq), 128'(0));
    for (int i = 0; i < NUM_REQ; i++) chk("rst_iresps", 128'(iresps[i]), 128'(0));
    chk("rst_fx_busy", 128'(f_busy), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    drive_oresp();

    // Single master 2, read len=4 at 0x1fc0_0000, memory ready every beat.
    clear_beats();
    load_req(2, 1'b0, 32'h1fc0_0000, 32'h0, 4'h0, 4);
    reqs_left[2] = 1;
    exp_q.push_back(2'd2);
    tick();
    chk("arb_latency_valid", 128'(oreq.valid), 128'(1));
    run_until_idle(40);
    chk("t1_beats", 128'(beats_seen[2]), 128'(4));
    chk("t1_last_beat", 128'(last_at[2]), 128'(4));
    chk("t1_rr_ptr", 128'(dbg_rr_ptr), 128'(3));

    // rr_ptr=3: master 3 requests twice, master 1 once -> 3, 1, 3.
    rand_ready = 1'b1;
    load_rand(3); reqs_left[3] = 2;
    load_rand(1); reqs_left[1] = 1;
    exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    run_until_idle(80);
    chk("t3_order_done", 128'(exp_q.size()), 128'(0));

    // All four at once, len=1, rr_ptr=0 -> 0, 1, 2, 3.
    for (int i = 0; i < NUM_REQ; i++) begin
      load_req(i, 1'b0, 32'h1000 * (i + 1), 32'h0, 4'h0, 1);
      reqs_left[i] = 1;
      exp_q.push_back(SEL_W'(i));
    end
    run_until_idle(40);
    chk("t2_order_done", 128'(exp_q.size()), 128'(0));

    // Write burst len=8 from master 1; master 3 joins while it is running.
    rand_ready = 1'b0;
    load_req(1, 1'b1, 32'h8000_0040, 32'hdead_beef, 4'hf, 8);
    reqs_left[1] = 1;
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    tick();
    load_rand(3); reqs_left[3] = 1;
    chk("wr_data", 128'(oreq.data), 128'(32'hdead_beef));
    chk("wr_strobe", 128'(oreq.strobe), 128'(4'hf));
    chk("wr_is_write", 128'(oreq.is_write), 128'(1));
    run_until_idle(60);

    // Reset during beat 3 of 8.
    load_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 1);
    reqs_left[1] = 1;
    exp_q.push_back(2'd1);
    run_until_idle(20);
    chk("pre_rst_ptr", 128'(dbg_rr_ptr), 128'(2));
    load_req(2, 1'b0, 32'h80, 32'h0, 4'h0, 8);
    reqs_left[2] = 1;
    tick(); tick(); tick();
    #2;
    oresp.ready = 1'b1; oresp.last = 1'b0; oresp.data = 32'h5555_aaaa;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_oreq", 128'(oreq), 128'(0));
    chk("midrst_iresps2", 128'(iresps[2]), 128'(0));
    chk("midrst_rr_ptr", 128'(dbg_rr_ptr), 128'(0));
    chk("midrst_grant", 128'(grant_idx), 128'(0));
    m_busy = 1'b0; m_ptr = 0; mem_beat = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ireqs[i].valid = 1'b0; reqs_left[i] = 0;
    end
    @(posedge clk);
    #1;
    chk("rst_hold_iresps2", 128'(iresps[2]), 128'(0));
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    drive_oresp();
    load_req(1, 1'b0, 32'h100, 32'h0, 4'h0, 2); reqs_left[1] = 1;
    load_req(3, 1'b0, 32'h300, 32'h0, 4'h0, 2); reqs_left[3] = 1;
    exp_q.push_back(2'd1); exp_q.push_back(2'd3);
    run_until_idle(40);

    // Abort: master 0 drops valid after its first beat.
    load_req(0, 1'b0, 32'h200, 32'h0, 4'h0, 4);
    reqs_left[0] = 1;
    tick(); tick();
    ireqs[0].valid = 1'b0;
    reqs_left[0]   = 0;
    tick();
    tick();
    chk("abort_idle", 128'(busy), 128'(0));
    chk("abort_ptr", 128'(dbg_rr_ptr), 128'(1));

    // Randomized traffic against the model.
    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        reqs_left[i] = int'($urandom_range(0, 2));
        if (reqs_left[i] > 0) load_rand(i);
      end
      run_until_idle(400);
    end

    // Fixed priority: masters 0 and 3 valid, master 3 bursts twice.
    f_ireqs[0].valid = 1'b1; f_ireqs[0].len = 8'd1; f_ireqs[0].addr = 32'h100;
    f_ireqs[3].valid = 1'b1; f_ireqs[3].len = 8'd1; f_ireqs[3].addr = 32'h300;
    f_oresp.ready = 1'b1; f_oresp.last = 1'b1; f_oresp.data = 32'h1234_5678;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("fx_busy", 128'(f_busy), 128'(fb[c]));
      if (fb[c] != 0) begin
        chk("fx_grant", 128'(f_grant_idx), 128'(fg[c]));
        chk("fx_oreq", 128'(f_oreq), 128'(f_ireqs[fg[c]]));
        chk("fx_resp_win", 128'(f_iresps[fg[c]]), 128'(f_oresp));
        chk("fx_resp_lose", 128'(f_iresps[3 - fg[c]]), 128'(0));
      end
      @(posedge clk);
      #1;
      if (c == 3) f_ireqs[3].valid = 1'b0;
      if (c == 5) f_ireqs[0].valid = 1'b0;
    end
    #1;
    chk("fx_final_idle", 128'(f_busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
